cam_stream_gen: RTL and testbench
=================================

CAM_STREAM_GEN -- requirements
Module: cam_stream_gen

Interface
REQ-001 Parameter H_ACTIVE, default 320: active pixels per line.
REQ-002 Parameter V_ACTIVE, default 240: active lines per frame.
REQ-003 Parameter BPP, default 2: bytes per pixel; 2 = RGB565, 1 = 8-bit gray; other values illegal.
REQ-004 Parameter H_BLANK, default 144: PCLK periods with HREF low between lines.
REQ-005 Parameter VS_PCLKS / VB_PCLKS / VF_PCLKS, defaults 1568 / 8000 / 4000: PCLK periods of VSYNC high / back porch / front porch.
REQ-006 Parameter PCLK_DIV, default 1 (>=1): PCLK_cam half-period in clk50 cycles.
REQ-007 clk50  in  1  sole clock; all logic on rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-low.
REQ-009 enable  in  1  run request; level-sensitive.
REQ-010 pattern_sel  in  2  0 ramp, 1 colour bars, 2 checkerboard, 3 constant.
REQ-011 const_px  in  16  pixel value for pattern 3 (gray uses [7:0]).
REQ-012 PCLK_cam  out  1  generated pixel clock.
REQ-013 VSYNC_cam, HREF_cam  out  1 each  frame / line qualifiers, active-high.
REQ-014 data_cam  out  8  pixel byte stream.
REQ-015 frame_cnt  out  16  completed frames, wraps 0xFFFF->0.
REQ-016 busy  out  1  high outside IDLE.

Function
REQ-017 PCLK_cam toggles every PCLK_DIV clk50 cycles whenever rst is high, independent of state; one byte slot = one PCLK period.
REQ-018 data_cam, HREF_cam, VSYNC_cam change only on the clk50 edge that drives PCLK_cam low; stable across the PCLK_cam rising edge.
REQ-019 FSM states IDLE, VSYNC, VBACK, ACTIVE, HBLANK, VFRONT.
REQ-020 IDLE->VSYNC at a PCLK falling edge with enable high; pattern_sel and const_px sampled then and held for the whole frame.
REQ-021 VSYNC (VS_PCLKS slots, VSYNC_cam=1) -> VBACK (VB_PCLKS) -> ACTIVE (H_ACTIVE*BPP slots, HREF_cam=1) -> HBLANK (H_BLANK) -> ACTIVE until V_ACTIVE lines done -> VFRONT (VF_PCLKS) -> VSYNC if enable, else IDLE.
REQ-022 After the last line, HBLANK still completes before VFRONT.
REQ-023 enable deasserted mid-frame: current frame completes; no truncated frames.
REQ-024 frame_cnt increments by 1 on VFRONT exit.
REQ-025 data_cam = 0x00 whenever HREF_cam = 0.
REQ-026 RGB565 emitted high byte first; gray emits the 8-bit value.
REQ-027 Pattern 0: gray = x[7:0]; RGB565 = {x[4:0], x[5:0], x[4:0]}, x = pixel column.
REQ-028 Pattern 1: 8 equal bars of width H_ACTIVE/8 (integer), remainder columns use bar 7; bar order white, yellow, cyan, green, magenta, red, blue, black (RGB565 full-scale; gray 0xFF down to 0x00 in equal steps of 0x24, last forced 0x00).
REQ-029 Pattern 2: 8x8 checkerboard, (x[3]^y[3]) ? white : black; white = 0xFFFF / 0xFF.
REQ-030 Pattern 3: const_px every pixel.
REQ-031 Counters sized by $clog2 of their parameter maximum; no wrap inside a frame.

Reset
REQ-032 rst low: state IDLE, PCLK_cam=0, VSYNC_cam=0, HREF_cam=0, data_cam=0x00, frame_cnt=0, busy=0, divider and all counters 0; asserting mid-frame aborts immediately.
REQ-033 First PCLK_cam rising edge occurs PCLK_DIV clk50 cycles after rst release.

Configuration
REQ-034 Macro CAM_GEN_FRAME_TAG_EN defined: first two active bytes of each frame replaced by frame_cnt[15:8], frame_cnt[7:0] (frame_cnt value at VSYNC entry); undefined: no substitution, pattern data only.

Verification
REQ-035 H_ACTIVE=4, V_ACTIVE=2, BPP=2, H_BLANK=2, VS/VB/VF=2, PCLK_DIV=1, pattern 3, const_px=0xABCD -> per line HREF high 8 PCLKs, bytes AB CD AB CD AB CD AB CD; 2 HREF pulses per VSYNC pulse.
REQ-036 Same geometry, BPP=1, pattern 0, H_ACTIVE=4 -> bytes 00 01 02 03 each line.
REQ-037 enable dropped during line 0 -> line 1 and VFRONT complete, frame_cnt 0->1, then IDLE, busy=0.
REQ-038 rst low during ACTIVE -> same clk50 edge: HREF_cam=0, data_cam=0, frame_cnt=0, busy=0.
REQ-039 PCLK_DIV=3 -> PCLK_cam period 6 clk50 cycles; data_cam never changes within 3 cycles before a PCLK_cam rising edge.
REQ-040 With CAM_GEN_FRAME_TAG_EN, third frame first bytes = 00 02; without it = pattern data.

Source files
------------

// File: rtl/cam_stream_gen_if.sv
// Camera-side video bus of cam_stream_gen: pixel clock, frame/line qualifiers and byte stream.
interface cam_stream_gen_if;
    logic       PCLK_cam;
    logic       VSYNC_cam;
    logic       HREF_cam;
    logic [7:0] data_cam;

    modport master (output PCLK_cam, output VSYNC_cam, output HREF_cam, output data_cam);
    modport slave  (input  PCLK_cam, input  VSYNC_cam, input  HREF_cam, input  data_cam);
endinterface

// File: rtl/cam_stream_gen.sv
// OV-style camera stream generator: ramp / colour bars / checkerboard / constant test frames.
// Optional macro CAM_GEN_FRAME_TAG_EN replaces the first two active bytes of a frame with frame_cnt.
module cam_stream_gen #(
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 240,
    parameter int BPP      = 2,
    parameter int H_BLANK  = 144,
    parameter int VS_PCLKS = 1568,
    parameter int VB_PCLKS = 8000,
    parameter int VF_PCLKS = 4000,
    parameter int PCLK_DIV = 1
) (
    input  logic             clk50,
    input  logic             rst,
    input  logic             enable,
    input  logic [1:0]       pattern_sel,
    input  logic [15:0]      const_px,
    cam_stream_gen_if.master cam,
    output logic [15:0]      frame_cnt,
    output logic             busy
);
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int BLANK_MAX = (VS_PCLKS > VB_PCLKS ? VS_PCLKS : VB_PCLKS) >
                               (VF_PCLKS > H_BLANK ? VF_PCLKS : H_BLANK) ?
                               (VS_PCLKS > VB_PCLKS ? VS_PCLKS : VB_PCLKS) :
                               (VF_PCLKS > H_BLANK ? VF_PCLKS : H_BLANK);
    localparam int XW      = cw(H_ACTIVE);
    localparam int YW      = cw(V_ACTIVE);
    localparam int BW      = cw(BLANK_MAX);
    localparam int DW      = cw(PCLK_DIV);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BAR_DIV = (BAR_W > 0) ? BAR_W : 1;

    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, HBLANK, VFRONT} state_t;

    state_t          state;
    logic [DW-1:0]   div_cnt;
    logic [BW-1:0]   blank_cnt;
    logic [XW-1:0]   px_x;
    logic            px_b;
    logic [YW-1:0]   line;
    logic [1:0]      pat_q;
    logic [15:0]     cpx_q;

    logic            fall;
    logic [XW-1:0]   emit_x;
    logic            emit_b;
    logic [YW-1:0]   emit_y;
    logic [7:0]      xr;
    logic            chk;
    logic [2:0]      bar;
    logic [15:0]     bar_rgb;
    logic [7:0]      bar_gray;
    logic [15:0]     word;
    logic [7:0]      next_byte;

    assign fall = cam.PCLK_cam && (div_cnt == DW'(PCLK_DIV - 1));

    // Position of the byte that the next falling edge will put on the bus.
    always_comb begin
        emit_x = '0;
        emit_b = 1'b0;
        emit_y = line;
        if (state == ACTIVE) begin
            if (px_b == 1'(BPP - 1)) begin
                emit_x = px_x + 1'b1;
            end else begin
                emit_x = px_x;
                emit_b = px_b + 1'b1;
            end
        end else if (state == HBLANK) begin
            emit_y = line + 1'b1;
        end else if (state == VBACK) begin
            emit_y = '0;
        end
    end

    always_comb begin
        xr  = 8'(emit_x);
        chk = 1'((32'(emit_x) ^ 32'(emit_y)) >> 3);
        bar = 3'd7;
        if (BAR_W > 0 && int'(emit_x) < 8 * BAR_W)
            bar = 3'(emit_x / XW'(BAR_DIV));
        case (bar)
            3'd0:    begin bar_rgb = 16'hFFFF; bar_gray = 8'hFF; end
            3'd1:    begin bar_rgb = 16'hFFE0; bar_gray = 8'hDB; end
            3'd2:    begin bar_rgb = 16'h07FF; bar_gray = 8'hB7; end
            3'd3:    begin bar_rgb = 16'h07E0; bar_gray = 8'h93; end
            3'd4:    begin bar_rgb = 16'hF81F; bar_gray = 8'h6F; end
            3'd5:    begin bar_rgb = 16'hF800; bar_gray = 8'h4B; end
            3'd6:    begin bar_rgb = 16'h001F; bar_gray = 8'h27; end
            default: begin bar_rgb = 16'h0000; bar_gray = 8'h00; end
        endcase
    end

    always_comb begin
        case (pat_q)
            2'd0:    word = (BPP == 1) ? {8'h00, xr} : {xr[4:0], xr[5:0], xr[4:0]};
            2'd1:    word = (BPP == 1) ? {8'h00, bar_gray} : bar_rgb;
            2'd2:    word = chk ? 16'hFFFF : 16'h0000;
            default: word = cpx_q;
        endcase
        next_byte = (BPP == 2 && emit_b == 1'b0) ? word[15:8] : word[7:0];
`ifdef CAM_GEN_FRAME_TAG_EN
        if (emit_y == '0 && emit_x <= XW'(2 / BPP - 1))
            next_byte = ((BPP == 2) ? (emit_b == 1'b0) : (emit_x == '0)) ?
                        frame_cnt[15:8] : frame_cnt[7:0];
`endif
    end

    // Divider runs unconditionally; all bus updates happen on the edge that drops PCLK.
    always_ff @(posedge clk50 or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            div_cnt       <= '0;
            blank_cnt     <= '0;
            px_x          <= '0;
            px_b          <= 1'b0;
            line          <= '0;
            pat_q         <= '0;
            cpx_q         <= '0;
            frame_cnt     <= '0;
            busy          <= 1'b0;
            cam.PCLK_cam  <= 1'b0;
            cam.VSYNC_cam <= 1'b0;
            cam.HREF_cam  <= 1'b0;
            cam.data_cam  <= '0;
        end else begin
            if (div_cnt == DW'(PCLK_DIV - 1)) begin
                div_cnt      <= '0;
                cam.PCLK_cam <= ~cam.PCLK_cam;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (fall) begin
                case (state)
                    IDLE: if (enable) begin
                        state         <= VSYNC;
                        pat_q         <= pattern_sel;
                        cpx_q         <= const_px;
                        cam.VSYNC_cam <= 1'b1;
                        busy          <= 1'b1;
                        blank_cnt     <= '0;
                    end
                    VSYNC: if (blank_cnt == BW'(VS_PCLKS - 1)) begin
                        state         <= VBACK;
                        cam.VSYNC_cam <= 1'b0;
                        blank_cnt     <= '0;
                    end else begin
                        blank_cnt <= blank_cnt + 1'b1;
                    end
                    VBACK: if (blank_cnt == BW'(VB_PCLKS - 1)) begin
                        state        <= ACTIVE;
                        px_x         <= '0;
                        px_b         <= 1'b0;
                        line         <= '0;
                        cam.HREF_cam <= 1'b1;
                        cam.data_cam <= next_byte;
                    end else begin
                        blank_cnt <= blank_cnt + 1'b1;
                    end
                    ACTIVE: if (px_x == XW'(H_ACTIVE - 1) && px_b == 1'(BPP - 1)) begin
                        state        <= HBLANK;
                        blank_cnt    <= '0;
                        cam.HREF_cam <= 1'b0;
                        cam.data_cam <= '0;
                    end else begin
                        px_x         <= emit_x;
                        px_b         <= emit_b;
                        cam.data_cam <= next_byte;
                    end
                    HBLANK: if (blank_cnt == BW'(H_BLANK - 1)) begin
                        blank_cnt <= '0;
                        if (line == YW'(V_ACTIVE - 1)) begin
                            state <= VFRONT;
                        end else begin
                            state        <= ACTIVE;
                            line         <= emit_y;
                            px_x         <= '0;
                            px_b         <= 1'b0;
                            cam.HREF_cam <= 1'b1;
                            cam.data_cam <= next_byte;
                        end
                    end else begin
                        blank_cnt <= blank_cnt + 1'b1;
                    end
                    VFRONT: if (blank_cnt == BW'(VF_PCLKS - 1)) begin
                        frame_cnt <= frame_cnt + 1'b1;
                        blank_cnt <= '0;
                        if (enable) begin
                            state         <= VSYNC;
                            pat_q         <= pattern_sel;
                            cpx_q         <= const_px;
                            cam.VSYNC_cam <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        blank_cnt <= blank_cnt + 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cam_stream_gen.sv
// Bench for cam_stream_gen: two small-geometry instances (RGB565/div1 and gray/div3) checked against a frame-level model.
module tb_cam_stream_gen;
    localparam int LIM = 20000;

    logic clk50 = 1'b0;
    always #10 clk50 = ~clk50;

    logic        rst[2];
    logic        en[2];
    logic [1:0]  pat[2];
    logic [15:0] cpx[2];
    logic [15:0] fcnt_a, fcnt_b;
    logic        busy_a, busy_b;

    cam_stream_gen_if ifa ();
    cam_stream_gen_if ifb ();

    cam_stream_gen #(.H_ACTIVE(20), .V_ACTIVE(10), .BPP(2), .H_BLANK(3),
                     .VS_PCLKS(2), .VB_PCLKS(3), .VF_PCLKS(2), .PCLK_DIV(1)) dut_a (
        .clk50(clk50), .rst(rst[0]), .enable(en[0]), .pattern_sel(pat[0]), .const_px(cpx[0]),
        .cam(ifa.master), .frame_cnt(fcnt_a), .busy(busy_a));

    cam_stream_gen #(.H_ACTIVE(4), .V_ACTIVE(2), .BPP(1), .H_BLANK(2),
                     .VS_PCLKS(2), .VB_PCLKS(2), .VF_PCLKS(2), .PCLK_DIV(3)) dut_b (
        .clk50(clk50), .rst(rst[1]), .enable(en[1]), .pattern_sel(pat[1]), .const_px(cpx[1]),
        .cam(ifb.master), .frame_cnt(fcnt_b), .busy(busy_b));

    int gh[2]  = '{20, 4};
    int gv[2]  = '{10, 2};
    int gb[2]  = '{2, 1};
    int ghb[2] = '{3, 2};
    int gvs[2] = '{2, 2};
    int gvb[2] = '{3, 2};
    int gvf[2] = '{2, 2};
    int gd[2]  = '{1, 3};
    int rgb[8] = '{'hFFFF, 'hFFE0, 'h07FF, 'h07E0, 'hF81F, 'hF800, 'h001F, 'h0000};

    logic        pclk_s[2], vs_s[2], href_s[2], busy_s[2];
    logic [7:0]  data_s[2];
    logic [15:0] fcnt[2];
    assign pclk_s[0] = ifa.PCLK_cam;  assign pclk_s[1] = ifb.PCLK_cam;
    assign vs_s[0]   = ifa.VSYNC_cam; assign vs_s[1]   = ifb.VSYNC_cam;
    assign href_s[0] = ifa.HREF_cam;  assign href_s[1] = ifb.HREF_cam;
    assign data_s[0] = ifa.data_cam;  assign data_s[1] = ifb.data_cam;
    assign fcnt[0]   = fcnt_a;        assign fcnt[1]   = fcnt_b;
    assign busy_s[0] = busy_a;        assign busy_s[1] = busy_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Slot capture: one {VSYNC, HREF, data} entry per PCLK rising edge.
    logic       cap_en[2] = '{1'b0, 1'b0};
    logic [9:0] cap0[$];
    logic [9:0] cap1[$];
    logic [9:0] expq[$];

    int   age[2]      = '{0, 0};
    int   since[2]    = '{0, 0};
    int   min_age[2]  = '{1000, 1000};
    int   per_min[2]  = '{1000, 1000};
    int   per_max[2]  = '{0, 0};
    logic seen[2]     = '{1'b0, 1'b0};
    logic prev_pclk[2];
    logic [9:0] prev_out[2];

    always @(negedge clk50) begin
        logic [9:0] cur;
        for (int k = 0; k < 2; k++) begin
            cur = {vs_s[k], href_s[k], data_s[k]};
            if (rst[k] !== 1'b1) begin
                age[k] = 0; since[k] = 0; seen[k] = 1'b0;
                prev_pclk[k] = 1'b0; prev_out[k] = cur;
            end else begin
                if (cur !== prev_out[k]) age[k] = 0; else age[k]++;
                since[k]++;
                if (pclk_s[k] && !prev_pclk[k]) begin
                    if (age[k] < min_age[k]) min_age[k] = age[k];
                    if (seen[k]) begin
                        if (since[k] < per_min[k]) per_min[k] = since[k];
                        if (since[k] > per_max[k]) per_max[k] = since[k];
                    end
                    seen[k] = 1'b1; since[k] = 0;
                    if (cap_en[k]) begin
                        if (k == 0) cap0.push_back(cur); else cap1.push_back(cur);
                    end
                end
                prev_pclk[k] = pclk_s[k]; prev_out[k] = cur;
            end
        end
    end

    function automatic int exp_byte(input int k, input int p, input int c, input int lb,
                                    input int y, input int fidx);
        int bpp, x, bi, w, bw, bar;
        bpp = gb[k]; x = lb / bpp; bi = lb % bpp;
        case (p)
            0: w = (bpp == 1) ? (x & 255) : (((x & 31) << 11) | ((x & 63) << 5) | (x & 31));
            1: begin
                bw  = gh[k] / 8;
                bar = (bw == 0) ? 7 : x / bw;
                if (bar > 7) bar = 7;
                w = (bpp == 1) ? ((bar == 7) ? 0 : 255 - 36 * bar) : rgb[bar];
            end
            2: w = (((x >> 3) ^ (y >> 3)) & 1) ? 'hFFFF : 0;
            default: w = c;
        endcase
`ifdef CAM_GEN_FRAME_TAG_EN
        if (y == 0 && lb < 2) return (lb == 0) ? ((fidx >> 8) & 255) : (fidx & 255);
`endif
        return (bpp == 2 && bi == 0) ? ((w >> 8) & 255) : (w & 255);
    endfunction

    task automatic append_frame(input int k, input int p, input int c, input int fidx);
        for (int i = 0; i < gvs[k]; i++) expq.push_back(10'h200);
        for (int i = 0; i < gvb[k]; i++) expq.push_back(10'h000);
        for (int y = 0; y < gv[k]; y++) begin
            for (int lb = 0; lb < gh[k] * gb[k]; lb++)
                expq.push_back({2'b01, 8'(exp_byte(k, p, c, lb, y, fidx))});
            for (int i = 0; i < ghb[k]; i++) expq.push_back(10'h000);
        end
        for (int i = 0; i < gvf[k]; i++) expq.push_back(10'h000);
    endtask

    task automatic test_reset();
        int first[2];
        rst[0] = 1'b0; rst[1] = 1'b0;
        repeat (3) @(negedge clk50);
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if ({pclk_s[k], vs_s[k], href_s[k], busy_s[k]} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_ctrl inst%0d: pclk/vs/href/busy=%b required 0000", k,
                         {pclk_s[k], vs_s[k], href_s[k], busy_s[k]});
            end
            n_tests++;
            if (data_s[k] !== 8'h00) begin
                n_fail++; $display("FAIL reset_data inst%0d: got %h required 00", k, data_s[k]);
            end
            n_tests++;
            if (fcnt[k] !== 16'h0000) begin
                n_fail++; $display("FAIL reset_fcnt inst%0d: got %h required 0000", k, fcnt[k]);
            end
        end
        first = '{0, 0};
        @(negedge clk50);
        rst[0] = 1'b1; rst[1] = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk50); #1;
            for (int k = 0; k < 2; k++) if (first[k] == 0 && pclk_s[k] === 1'b1) first[k] = c;
        end
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (first[k] != gd[k]) begin
                n_fail++;
                $display("FAIL first_pclk_rise inst%0d: after %0d cycles required %0d", k, first[k], gd[k]);
            end
        end
    endtask

    task automatic test_stream(input int k, input int nfr, input int p0);
        int p1, c0, c1, c, i, j, bad_at;
        logic [9:0] cq[$];
        logic [9:0] got;
        p1 = $urandom_range(0, 3); c0 = $urandom_range(0, 65535); c1 = $urandom_range(0, 65535);
        rst[k] = 1'b0; en[k] = 1'b0; cap_en[k] = 1'b0;
        repeat (3) @(negedge clk50);
        if (k == 0) cap0.delete(); else cap1.delete();
        pat[k] = 2'(p0); cpx[k] = 16'(c0);
        rst[k] = 1'b1; cap_en[k] = 1'b1; en[k] = 1'b1;
        for (c = 0; c < LIM && vs_s[k] !== 1'b1; c++) @(negedge clk50);
        pat[k] = 2'(p1); cpx[k] = 16'(c1);
        for (c = 0; c < LIM && !(fcnt[k] == 16'(nfr - 1) && href_s[k] === 1'b1); c++) @(negedge clk50);
        en[k] = 1'b0;
        n_tests++;
        if (busy_s[k] !== 1'b1) begin
            n_fail++; $display("FAIL busy_hold inst%0d: got %b required 1", k, busy_s[k]);
        end
        for (c = 0; c < LIM && busy_s[k] !== 1'b0; c++) @(negedge clk50);
        n_tests++;
        if (fcnt[k] !== 16'(nfr) || busy_s[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_end inst%0d: frame_cnt=%0d busy=%b required %0d and 0", k, fcnt[k], busy_s[k], nfr);
        end
        repeat (20 * gd[k]) @(negedge clk50);
        cap_en[k] = 1'b0;
        if (k == 0) cq = cap0; else cq = cap1;
        expq.delete();
        for (int f = 0; f < nfr; f++) append_frame(k, (f == 0) ? p0 : p1, (f == 0) ? c0 : c1, f);
        i = 0;
        while (i < cq.size() && cq[i] === 10'h000) i++;
        bad_at = -1; got = 10'h3FF;
        for (j = 0; j < expq.size(); j++) begin
            if (i + j >= cq.size() || cq[i + j] !== expq[j]) begin
                bad_at = j; got = (i + j < cq.size()) ? cq[i + j] : 10'h3FF; break;
            end
        end
        if (bad_at < 0)
            for (int t = i + expq.size(); t < cq.size(); t++)
                if (cq[t] !== 10'h000 && bad_at < 0) begin bad_at = t - i; got = cq[t]; end
        n_tests++;
        if (bad_at >= 0) begin
            n_fail++;
            $display("FAIL stream inst%0d pat%0d/%0d slot %0d: got {vs,href,data}=%h required %h", k, p0, p1,
                     bad_at, got, (bad_at < expq.size()) ? expq[bad_at] : 10'h000);
        end
    endtask

    task automatic test_reset_mid_active();
        int c, viol;
        rst[0] = 1'b0; en[0] = 1'b0;
        repeat (2) @(negedge clk50);
        pat[0] = 2'd3; cpx[0] = 16'hABCD; rst[0] = 1'b1; en[0] = 1'b1;
        for (c = 0; c < LIM && !(fcnt[0] == 16'd1 && href_s[0] === 1'b1); c++) @(negedge clk50);
        @(negedge clk50); #3;
        rst[0] = 1'b0;
        #1;
        n_tests++;
        if ({href_s[0], vs_s[0], busy_s[0], pclk_s[0]} !== 4'b0000 || data_s[0] !== 8'h00) begin
            n_fail++;
            $display("FAIL async_abort: href/vs/busy/pclk=%b data=%h required 0000 00",
                     {href_s[0], vs_s[0], busy_s[0], pclk_s[0]}, data_s[0]);
        end
        n_tests++;
        if (fcnt[0] !== 16'h0000) begin
            n_fail++; $display("FAIL async_fcnt: got %h required 0000", fcnt[0]);
        end
        en[0] = 1'b0;
        @(negedge clk50); rst[0] = 1'b1;
        viol = 0;
        repeat (40) begin @(negedge clk50); if (busy_s[0] !== 1'b0 || vs_s[0] !== 1'b0) viol++; end
        n_tests++;
        if (viol != 0) begin
            n_fail++; $display("FAIL idle_stays: %0d cycles active, required 0", viol);
        end
    endtask

    task automatic test_pclk_timing();
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (per_min[k] != 2 * gd[k] || per_max[k] != 2 * gd[k]) begin
                n_fail++;
                $display("FAIL pclk_period inst%0d: min %0d max %0d required %0d", k, per_min[k], per_max[k], 2 * gd[k]);
            end
            n_tests++;
            if (min_age[k] != gd[k]) begin
                n_fail++;
                $display("FAIL setup_before_rise inst%0d: %0d cycles required %0d", k, min_age[k], gd[k]);
            end
        end
    endtask

    initial begin
        rst[0] = 1'b0; rst[1] = 1'b0; en[0] = 1'b0; en[1] = 1'b0;
        pat[0] = '0; pat[1] = '0; cpx[0] = '0; cpx[1] = '0;
        test_reset();
        test_stream(0, 2, 3);
        test_stream(0, 1, 0);
        test_stream(0, 2, 1);
        test_stream(0, 3, 2);
        test_stream(1, 1, 0);
        test_stream(1, 3, 3);
        test_stream(1, 2, 1);
        test_stream(1, 2, 2);
        test_reset_mid_active();
        test_pclk_timing();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
